priv_key_vault: RTL

- Secret-storage stage directly downstream of the software request adaptor.
- Consumes the adaptor's `key_hash`, `req_type` and `key_en`. Returns the 128-bit `priv_data` word that the adaptor streams back to software.
- Holds a small table of tagged secrets loaded over a trusted provisioning port. Searches it sequentially, one entry per cycle, and holds the result stable on `priv_data` until the next completed request.

---
 rtl/priv_key_vault.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/priv_key_vault.sv
// priv_key_vault: tagged secret table with a sequential one-entry-per-cycle search.
// Optional provisioning lock is enabled by defining KV_PROV_LOCK_EN.
module priv_key_vault #(
    parameter int KH_S    = 64,
    parameter int D_S     = 128,
    parameter int DT_S    = 3,
    parameter int ENTRIES = 8,
    parameter int IDX_W   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KH_S-1:0]  key_hash,
    input  logic [DT_S-1:0]  req_type,
    input  logic             key_en,
    input  logic             prov_valid,
    input  logic [IDX_W-1:0] prov_idx,
    input  logic [KH_S-1:0]  prov_tag,
    input  logic [D_S-1:0]   prov_data,
`ifdef KV_PROV_LOCK_EN
    input  logic             prov_lock,
`endif
    output logic [D_S-1:0]   priv_data,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic             err,
    output logic [7:0]       drop_cnt
);

    localparam logic [DT_S-1:0] OP_LOOKUP = DT_S'(0);
    localparam logic [DT_S-1:0] OP_INVAL  = DT_S'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    typedef enum logic {IDLE, SEARCH} state_t;

    state_t            state;
    state_t            state_nx;
    logic [IDX_W-1:0]  idx;
    logic [KH_S-1:0]   cap_hash;
    logic [DT_S-1:0]   cap_type;
    logic [ENTRIES-1:0] valid;
    logic [KH_S-1:0]   tags [ENTRIES];
    logic [D_S-1:0]    data [ENTRIES];
    logic              prov_en;
    logic              legal;
    logic              cmp_en;
    logic              match;
    logic              last;

`ifdef KV_PROV_LOCK_EN
    logic locked;

    // Sticky lock; a write in the locking cycle itself still lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            locked <= 1'b0;
        else if (prov_lock)
            locked <= 1'b1;
    end

    assign prov_en = prov_valid && !locked;
`else
    assign prov_en = prov_valid;
`endif

    assign busy = (state == SEARCH);

    // Next-state logic; a provisioning write stalls the compare.
    always_comb begin
        state_nx = state;
        legal    = (req_type == OP_LOOKUP) || (req_type == OP_INVAL);
        cmp_en   = (state == SEARCH) && !prov_en;
        match    = valid[idx] && (tags[idx] == cap_hash);
        last     = (idx == LAST_IDX);
        unique case (state)
            IDLE: begin
                if (key_en && legal)
                    state_nx = SEARCH;
            end
            SEARCH: begin
                if (cmp_en && (match || last))
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Request capture, search index, results, valid bits, drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            cap_hash  <= '0;
            cap_type  <= '0;
            valid     <= '0;
            priv_data <= '0;
            done      <= 1'b0;
            hit       <= 1'b0;
            err       <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (prov_en)
                valid[prov_idx] <= 1'b1;
            if (state == IDLE && key_en) begin
                cap_hash <= key_hash;
                cap_type <= req_type;
                idx      <= '0;
                if (!legal) begin
                    done <= 1'b1;
                    err  <= 1'b1;
                    hit  <= 1'b0;
                end
            end
            if (state == SEARCH && key_en && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
            if (cmp_en) begin
                if (match) begin
                    done <= 1'b1;
                    hit  <= 1'b1;
                    err  <= 1'b0;
                    if (cap_type == OP_LOOKUP) begin
                        priv_data <= data[idx];
                    end else begin
                        priv_data  <= '0;
                        valid[idx] <= 1'b0;
                    end
                end else if (last) begin
                    done      <= 1'b1;
                    hit       <= 1'b0;
                    err       <= 1'b0;
                    priv_data <= '0;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

    // Secret storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (prov_en) begin
            tags[prov_idx] <= prov_tag;
            data[prov_idx] <= prov_data;
        end
    end

endmodule
